// File: rtl/bullet_controller.sv
// Per-slot bullet controller: launches from the owning tank on request, steps once
// per frame, explodes on collision or field edge, then returns to idle.
module bullet_controller #(
   parameter logic [8:0] Bullet_Size    = 9'd4,
   parameter logic [8:0] Tank_Size      = 9'd32,
   parameter logic [8:0] Bullet_Speed   = 9'd2,
   parameter logic [8:0] Field_Max      = 9'd415,
   parameter logic [3:0] Explode_Frames = 4'd8
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic       fire,
   input  logic [8:0] Tank_X,
   input  logic [8:0] Tank_Y,
   input  logic [1:0] Tank_Dir,
   input  logic       hit_bullet,
   input  logic       hit_wall,
   input  logic       hit_tank,
   output logic [8:0] Bullet_X,
   output logic [8:0] Bullet_Y,
   output logic [1:0] Bullet_State,
   output logic [1:0] Bullet_Dir,
   output logic       fire_ack,
   output logic       explode_done
);

   typedef enum logic [1:0] {IDLE = 2'b00, FLYING = 2'b01, EXPLODE = 2'b10} state_t;

   // 10-bit working width keeps edge sums from wrapping.
   localparam logic [9:0] BS   = {1'b0, Bullet_Size};
   localparam logic [9:0] TS   = {1'b0, Tank_Size};
   localparam logic [9:0] SPD  = {1'b0, Bullet_Speed};
   localparam logic [9:0] LIM  = {1'b0, Field_Max} + 10'd1;
   localparam logic [9:0] EDGE = LIM - BS;
   localparam logic [9:0] OFF  = (TS - BS) >> 1;

   state_t     state_q, state_d;
   logic [8:0] x_q, x_d, y_q, y_d;
   logic [1:0] dir_q, dir_d;
   logic       pend_q, pend_d;
   logic [3:0] cnt_q, cnt_d;
   logic       ack_q, ack_d, done_q, done_d;

   logic [9:0] tx, ty, bx, by, sx, sy, nx, ny;
   logic       s_oob, n_oob, hit_any;

   assign tx      = {1'b0, Tank_X};
   assign ty      = {1'b0, Tank_Y};
   assign bx      = {1'b0, x_q};
   assign by      = {1'b0, y_q};
   assign hit_any = hit_bullet | hit_wall | hit_tank;

   // Spawn point just outside the tank's leading face, centred on the other axis.
   always_comb begin
      sx    = tx + OFF;
      sy    = ty + OFF;
      s_oob = 1'b0;
      case (Tank_Dir)
         2'b00: if (ty < BS) begin sy = '0; s_oob = 1'b1; end else sy = ty - BS;
         2'b01: begin
            sx = tx + TS;
            if (sx + BS > LIM) begin sx = EDGE; s_oob = 1'b1; end
         end
         2'b10: begin
            sy = ty + TS;
            if (sy + BS > LIM) begin sy = EDGE; s_oob = 1'b1; end
         end
         default: if (tx < BS) begin sx = '0; s_oob = 1'b1; end else sx = tx - BS;
      endcase
   end

   always_comb begin
      nx    = bx;
      ny    = by;
      n_oob = 1'b0;
      case (dir_q)
         2'b00: if (by < SPD) begin ny = '0; n_oob = 1'b1; end else ny = by - SPD;
         2'b01: if (bx + SPD + BS > LIM) begin nx = EDGE; n_oob = 1'b1; end else nx = bx + SPD;
         2'b10: if (by + SPD + BS > LIM) begin ny = EDGE; n_oob = 1'b1; end else ny = by + SPD;
         default: if (bx < SPD) begin nx = '0; n_oob = 1'b1; end else nx = bx - SPD;
      endcase
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      dir_d   = dir_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      ack_d   = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (fire) pend_d = 1'b1;
            if (frame_tick && (fire || pend_q)) begin
               pend_d = 1'b0;
               ack_d  = 1'b1;
               dir_d  = Tank_Dir;
               x_d    = sx[8:0];
               y_d    = sy[8:0];
               if (s_oob) begin
                  state_d = EXPLODE;
                  cnt_d   = Explode_Frames - 4'd1;
               end else begin
                  state_d = FLYING;
               end
            end
         end
         FLYING: if (frame_tick) begin
            if (hit_any) begin
               state_d = EXPLODE;
               cnt_d   = Explode_Frames - 4'd1;
            end else begin
               x_d = nx[8:0];
               y_d = ny[8:0];
               if (n_oob) begin
                  state_d = EXPLODE;
                  cnt_d   = Explode_Frames - 4'd1;
               end
            end
         end
         EXPLODE: if (frame_tick) begin
            if (cnt_q == 4'd0) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         dir_q   <= '0;
         pend_q  <= 1'b0;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         dir_q   <= dir_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
      end
   end

   assign Bullet_X     = x_q;
   assign Bullet_Y     = y_q;
   assign Bullet_State = state_q;
   assign Bullet_Dir   = dir_q;
   assign fire_ack     = ack_q;
   assign explode_done = done_q;

endmodule

// File: tb/tb_bullet_controller.sv
// Bench for bullet_controller: directed scenarios with literal expectations, then random
// traffic, all compared each cycle against a coordinate-level reference model.
module tb_bullet_controller;

   logic       clk = 1'b0;
   logic       Reset = 1'b1;
   logic       frame_tick = 1'b0, fire = 1'b0;
   logic [8:0] Tank_X = '0, Tank_Y = '0;
   logic [1:0] Tank_Dir = '0;
   logic       hit_bullet = 1'b0, hit_wall = 1'b0, hit_tank = 1'b0;
   logic [8:0] Bullet_X, Bullet_Y;
   logic [1:0] Bullet_State, Bullet_Dir;
   logic       fire_ack, explode_done;

   int vectors = 0;
   int miscompares = 0;

   bullet_controller dut (
      .Clk(clk), .Reset(Reset), .frame_tick(frame_tick), .fire(fire),
      .Tank_X(Tank_X), .Tank_Y(Tank_Y), .Tank_Dir(Tank_Dir),
      .hit_bullet(hit_bullet), .hit_wall(hit_wall), .hit_tank(hit_tank),
      .Bullet_X(Bullet_X), .Bullet_Y(Bullet_Y), .Bullet_State(Bullet_State),
      .Bullet_Dir(Bullet_Dir), .fire_ack(fire_ack), .explode_done(explode_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: the bullet is a point in [0,412]^2 moving along a unit vector.
   int ms = 0, mx = 0, my = 0, md = 0, mleft = 0;
   bit mp = 0, mack = 0, mdone = 0;
   int dx, dy, nx, ny;
   bit out;

   function automatic int dir_dx(input int d);
      return (d == 1) ? 1 : (d == 3) ? -1 : 0;
   endfunction
   function automatic int dir_dy(input int d);
      return (d == 2) ? 1 : (d == 0) ? -1 : 0;
   endfunction

   always @(posedge clk) begin
      mack  = 0;
      mdone = 0;
      if (Reset) begin
         ms = 0; mx = 0; my = 0; md = 0; mp = 0; mleft = 0;
      end else begin
         if (ms == 0 && fire) mp = 1;
         if (frame_tick) begin
            if (ms == 0 && mp) begin
               md = int'(Tank_Dir);
               nx = int'(Tank_X) + 14 + 18 * dir_dx(md);
               ny = int'(Tank_Y) + 14 + 18 * dir_dy(md);
               out = 0;
               if (nx < 0) begin nx = 0; out = 1; end
               if (nx > 412) begin nx = 412; out = 1; end
               if (ny < 0) begin ny = 0; out = 1; end
               if (ny > 412) begin ny = 412; out = 1; end
               mx = nx; my = ny; mp = 0; mack = 1;
               if (out) begin ms = 2; mleft = 8; end else ms = 1;
            end else if (ms == 1) begin
               if (hit_bullet || hit_wall || hit_tank) begin
                  ms = 2; mleft = 8;
               end else begin
                  nx = mx + 2 * dir_dx(md);
                  ny = my + 2 * dir_dy(md);
                  out = 0;
                  if (nx < 0) begin nx = 0; out = 1; end
                  if (nx > 412) begin nx = 412; out = 1; end
                  if (ny < 0) begin ny = 0; out = 1; end
                  if (ny > 412) begin ny = 412; out = 1; end
                  mx = nx; my = ny;
                  if (out) begin ms = 2; mleft = 8; end
               end
            end else if (ms == 2) begin
               mleft--;
               if (mleft == 0) begin ms = 0; mdone = 1; end
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("x",     Bullet_X,            9'(mx));
      chk("y",     Bullet_Y,            9'(my));
      chk("state", {7'd0, Bullet_State}, 9'(ms));
      chk("dir",   {7'd0, Bullet_Dir},   9'(md));
      chk("ack",   {8'd0, fire_ack},     9'(mack));
      chk("done",  {8'd0, explode_done}, 9'(mdone));
   end

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); #1;
      end
   endtask

   // One cycle with frame_tick high; returns just after the sampling edge.
   task automatic tick();
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      cyc(1);
      Reset = 1'b0;
   endtask

   initial begin
      cyc(1);
      Reset = 1'b0;
      chk("rst_x", Bullet_X, 9'd0);
      chk("rst_y", Bullet_Y, 9'd0);
      chk("rst_state", {7'd0, Bullet_State}, 9'd0);
      chk("rst_dir", {7'd0, Bullet_Dir}, 9'd0);
      chk("rst_ack", {8'd0, fire_ack}, 9'd0);

      // Launch right from (100,200).
      Tank_X = 9'd100; Tank_Y = 9'd200; Tank_Dir = 2'b01;
      fire = 1'b1; cyc(1); fire = 1'b0;
      tick();
      chk("s1_ack", {8'd0, fire_ack}, 9'd1);
      chk("s1_x", Bullet_X, 9'd132);
      chk("s1_y", Bullet_Y, 9'd214);
      chk("s1_state", {7'd0, Bullet_State}, 9'd1);
      chk("s1_dir", {7'd0, Bullet_Dir}, 9'd1);
      for (int i = 0; i < 3; i++) tick();
      chk("s1_x3", Bullet_X, 9'd138);
      chk("s1_ack_low", {8'd0, fire_ack}, 9'd0);

      // Upward bullet reaching the top edge, then a full explosion.
      do_reset();
      Tank_X = 9'd100; Tank_Y = 9'd7; Tank_Dir = 2'b00;
      fire = 1'b1; tick(); fire = 1'b0;
      chk("s2_y3", Bullet_Y, 9'd3);
      chk("s2_x", Bullet_X, 9'd114);
      tick();
      chk("s2_y1", Bullet_Y, 9'd1);
      tick();
      chk("s2_y0", Bullet_Y, 9'd0);
      chk("s2_expl", {7'd0, Bullet_State}, 9'd2);
      for (int i = 0; i < 7; i++) tick();
      chk("s2_still_expl", {7'd0, Bullet_State}, 9'd2);
      tick();
      chk("s2_idle", {7'd0, Bullet_State}, 9'd0);
      chk("s2_done", {8'd0, explode_done}, 9'd1);

      // Double hit at (50,60); fire during explosion must not launch later.
      Tank_X = 9'd36; Tank_Y = 9'd64; Tank_Dir = 2'b00;
      fire = 1'b1; tick(); fire = 1'b0;
      chk("s3_pos", Bullet_Y, 9'd60);
      hit_bullet = 1'b1; hit_wall = 1'b1; tick(); hit_bullet = 1'b0; hit_wall = 1'b0;
      chk("s3_expl", {7'd0, Bullet_State}, 9'd2);
      chk("s3_x", Bullet_X, 9'd50);
      chk("s3_y", Bullet_Y, 9'd60);
      fire = 1'b1; cyc(1); fire = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      chk("s3_done", {8'd0, explode_done}, 9'd1);
      tick();
      chk("s3_no_launch", {7'd0, Bullet_State}, 9'd0);
      chk("s3_no_ack", {8'd0, fire_ack}, 9'd0);

      // Spawn off the left edge.
      Tank_X = 9'd0; Tank_Y = 9'd0; Tank_Dir = 2'b11;
      fire = 1'b1; tick(); fire = 1'b0;
      chk("s4_ack", {8'd0, fire_ack}, 9'd1);
      chk("s4_state", {7'd0, Bullet_State}, 9'd2);
      chk("s4_x", Bullet_X, 9'd0);
      for (int i = 0; i < 8; i++) tick();

      // Held fire request, then no relaunch while flying.
      Tank_X = 9'd200; Tank_Y = 9'd200; Tank_Dir = 2'b01;
      fire = 1'b1; cyc(1); fire = 1'b0;
      cyc(100);
      chk("s5_wait", {7'd0, Bullet_State}, 9'd0);
      tick();
      chk("s5_ack", {8'd0, fire_ack}, 9'd1);
      chk("s5_x", Bullet_X, 9'd232);
      fire = 1'b1; tick(); fire = 1'b0;
      chk("s5_no_ack", {8'd0, fire_ack}, 9'd0);
      chk("s5_x2", Bullet_X, 9'd234);

      // Reset in the middle of an explosion.
      hit_tank = 1'b1; tick(); hit_tank = 1'b0;
      tick(); tick();
      do_reset();
      chk("s6_state", {7'd0, Bullet_State}, 9'd0);
      chk("s6_x", Bullet_X, 9'd0);
      chk("s6_y", Bullet_Y, 9'd0);
      chk("s6_dir", {7'd0, Bullet_Dir}, 9'd0);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("s6_no_done", {8'd0, explode_done}, 9'd0);
      end

      // Random traffic, checked every cycle by the model.
      for (int i = 0; i < 20000; i++) begin
         Reset      = ($urandom_range(0, 999) == 0);
         fire       = ($urandom_range(0, 3) == 0);
         frame_tick = ($urandom_range(0, 2) == 0);
         hit_bullet = ($urandom_range(0, 99) == 0);
         hit_wall   = ($urandom_range(0, 99) == 0);
         hit_tank   = ($urandom_range(0, 99) == 0);
         Tank_Dir   = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) begin
            Tank_X = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 4)) : 9'($urandom_range(380, 384));
            Tank_Y = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 4)) : 9'($urandom_range(380, 384));
         end else begin
            Tank_X = 9'($urandom_range(0, 384));
            Tank_Y = 9'($urandom_range(0, 384));
         end
         cyc(1);
      end
      Reset = 1'b0; fire = 1'b0; frame_tick = 1'b0;
      cyc(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
